// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM states and helpers for the uart command parser.
// Responses are packed little-end first: byte 0 goes out first.
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_R  = 8'h52;

    // Clearing bit 5 folds lowercase ASCII letters onto uppercase
    localparam logic [7:0] CASE_MASK = 8'hDF;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_EXEC,
        ST_SEND,
        ST_WAIT
    } state_t;

    typedef logic [3:0][7:0] resp_t;

    localparam resp_t RESP_OK = {ASCII_LF, ASCII_CR, ASCII_K, ASCII_O};
    localparam resp_t RESP_ER = {ASCII_LF, ASCII_CR, ASCII_R, ASCII_E};

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_0 + {4'd0, n};
        else
            return ASCII_A + {4'd0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_resp_sender.sv
// Streams a 3- or 4-byte response into the uart transmitter,
// pacing each byte on the tx_busy handshake.
module uart_resp_sender
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  resp_t      resp,
    input  logic [2:0] resp_len,
    input  logic       tx_busy,
    output logic       tx_send,
    output logic [7:0] tx_data,
    output logic       done
);

    // ST_COLLECT doubles as the sender's idle state
    state_t      state, state_nxt;
    resp_t       resp_q, resp_nxt;
    logic [2:0]  len_q, len_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        first, first_nxt;
    logic [7:0]  data_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_COLLECT;
            resp_q  <= '0;
            len_q   <= '0;
            idx     <= '0;
            first   <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            state   <= state_nxt;
            resp_q  <= resp_nxt;
            len_q   <= len_nxt;
            idx     <= idx_nxt;
            first   <= first_nxt;
            tx_data <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        resp_nxt  = resp_q;
        len_nxt   = len_q;
        idx_nxt   = idx;
        first_nxt = first;
        data_nxt  = tx_data;
        tx_send   = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_send   = 1'b1;
                    first_nxt = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // tx_busy may lag tx_send by one cycle
                if (first) begin
                    first_nxt = 1'b0;
                end else if (!tx_busy) begin
                    if ({1'b0, idx} + 3'd1 < len_q) begin
                        idx_nxt   = idx + 2'd1;
                        data_nxt  = resp_q[idx + 2'd1];
                        state_nxt = ST_SEND;
                    end else begin
                        done      = 1'b1;
                        state_nxt = ST_COLLECT;
                    end
                end
            end
            default: begin
                if (start) begin
                    resp_nxt  = resp;
                    len_nxt   = resp_len;
                    idx_nxt   = 2'd0;
                    data_nxt  = resp[0];
                    state_nxt = ST_SEND;
                end
            end
        endcase
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles CR-terminated command lines from uart rx bytes, drives
// the LEDs and hands an ASCII response to the transmit sender.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int CMD_MAX_LEN = 8,
    parameter int NUM_LEDS    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                tx_busy,
    output logic                tx_send,
    output logic [7:0]          tx_data,
    output logic [NUM_LEDS-1:0] led,
    output logic                cmd_err,
    output logic                rx_drop
);

    localparam int LW = $clog2(CMD_MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(CMD_MAX_LEN);
    // Only the first two bytes can form a valid command; longer
    // lines are rejected on length alone, so later bytes are not kept.
    localparam logic [LW-1:0] KEEP = LW'(2);

    state_t              state, state_nxt;
    logic [LW-1:0]       len, len_nxt;
    logic                ovf, ovf_nxt;
    logic [7:0]          line [2];
    logic [NUM_LEDS-1:0] led_nxt;
    logic [7:0]          led8;
    logic                store;
    logic                is_l, is_s;
    logic                start, done;
    resp_t               resp;
    logic [2:0]          resp_len;

    assign store = (state == ST_COLLECT) && rx_valid &&
                   (rx_data != ASCII_CR) && (rx_data != ASCII_LF) &&
                   (len < KEEP);

    assign is_l = (len == LW'(2)) &&
                  ((line[0] & CASE_MASK) == ASCII_L) &&
                  (line[1] >= ASCII_0 + 8'd1) &&
                  (line[1] <= ASCII_0 + 8'(NUM_LEDS));

    assign is_s = (len == LW'(1)) &&
                  ((line[0] & CASE_MASK) == ASCII_S);

    assign led8    = 8'(led);
    assign rx_drop = rx_valid && (state != ST_COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_COLLECT;
            len   <= '0;
            ovf   <= 1'b0;
            led   <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
            ovf   <= ovf_nxt;
            led   <= led_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line[0] <= 8'h00;
            line[1] <= 8'h00;
        end else if (store) begin
            line[len[0]] <= rx_data;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        ovf_nxt   = ovf;
        led_nxt   = led;
        start     = 1'b0;
        resp      = RESP_ER;
        resp_len  = 3'd4;
        cmd_err   = 1'b0;
        unique case (state)
            ST_COLLECT: begin
                if (rx_valid) begin
                    if (rx_data == ASCII_CR) begin
                        state_nxt = ST_EXEC;
                    end else if (rx_data != ASCII_LF) begin
                        if (len == LEN_MAX)
                            ovf_nxt = 1'b1;
                        else
                            len_nxt = len + LW'(1);
                    end
                end
            end
            ST_EXEC: begin
                len_nxt   = '0;
                ovf_nxt   = 1'b0;
                start     = 1'b1;
                state_nxt = ST_SEND;
                if (ovf) begin
                    cmd_err = 1'b1;
                end else if (len == '0) begin
                    start     = 1'b0;
                    state_nxt = ST_COLLECT;
                end else if (is_l) begin
                    resp = RESP_OK;
                    for (int i = 0; i < NUM_LEDS; i++)
                        if (line[1] == ASCII_0 + 8'(i + 1))
                            led_nxt[i] = ~led[i];
                end else if (is_s) begin
                    if (NUM_LEDS > 4) begin
                        resp = {ASCII_LF, ASCII_CR,
                                nibble_to_hex(led8[3:0]),
                                nibble_to_hex(led8[7:4])};
                    end else begin
                        resp     = {8'h00, ASCII_LF, ASCII_CR,
                                    nibble_to_hex(led8[3:0])};
                        resp_len = 3'd3;
                    end
                end else begin
                    cmd_err = 1'b1;
                end
            end
            default: begin
                if (done)
                    state_nxt = ST_COLLECT;
            end
        endcase
    end

    uart_resp_sender u_sender (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .resp     (resp),
        .resp_len (resp_len),
        .tx_busy  (tx_busy),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .done     (done)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser with a uart tx model and
// a line-level reference model of the command rules.
module tb_uart_cmd_parser;

    localparam int MAXL = 8;
    localparam int NL   = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data  = 8'h00;
    logic          tx_busy  = 1'b0;
    logic          tx_send;
    logic [7:0]    tx_data;
    logic [NL-1:0] led;
    logic          cmd_err;
    logic          rx_drop;

    uart_cmd_parser #(.CMD_MAX_LEN(MAXL), .NUM_LEDS(NL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_busy  (tx_busy),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .led      (led),
        .cmd_err  (cmd_err),
        .rx_drop  (rx_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]    exp_q[$];
    logic [NL-1:0] m_led    = '0;
    int            exp_err  = 0;
    int            exp_drop = 0;
    int            tx_cnt   = 0;
    int            err_cnt  = 0;
    int            drop_cnt = 0;
    int            busy_left = 0;
    logic [7:0]    last_tx  = 8'h00;
    logic          hold_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    // uart transmitter: busy rises the cycle after tx_send
    always @(posedge clk) begin
        if (tx_send) begin
            tx_busy   <= 1'b1;
            busy_left <= int'($urandom_range(1, 5));
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    // monitor: pops the scoreboard on every transmitted byte
    always @(negedge clk) begin
        if (!rst_n) hold_chk = 1'b0;
        if (cmd_err) err_cnt++;
        if (rx_drop) drop_cnt++;
        if (tx_send) begin
            tx_cnt++;
            last_tx  = tx_data;
            hold_chk = 1'b1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_extra: got %0h want none", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
        end else if (tx_busy && hold_chk) begin
            check("tx_hold", tx_data, last_tx);
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
    endfunction

    task automatic push_er();
        exp_q.push_back("E");
        exp_q.push_back("R");
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        exp_err++;
    endtask

    // reference: what a complete line should produce
    task automatic model_line(input string s);
        logic [7:0] b[$];
        int         n;
        for (int i = 0; i < s.len(); i++)
            if (s[i] != 8'h0A) b.push_back(s[i]);
        if (b.size() == 0) return;
        if (b.size() > MAXL) begin
            push_er();
        end else if (b.size() == 2 && (b[0] == "L" || b[0] == "l") &&
                     b[1] >= "1" && b[1] <= 8'h30 + 8'(NL)) begin
            n = int'(b[1]) - 49;
            m_led[n] = ~m_led[n];
            exp_q.push_back("O");
            exp_q.push_back("K");
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else if (b.size() == 1 && (b[0] == "S" || b[0] == "s")) begin
            exp_q.push_back(hexc(4'(m_led)));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            push_er();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        model_line(s);
        send_byte(8'h0D);
    endtask

    task automatic wait_idle();
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < 3000) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !tx_busy) quiet++;
            else quiet = 0;
        end
        if (n >= 3000) begin
            fail("idle_wait");
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail("tx_wait");
    endtask

    initial begin
        string s;
        int    c0, e0, k;

        repeat (3) @(negedge clk);
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_led", led, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_rx_drop", rx_drop, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_line("L1");
        wait_idle();
        check("t1_led", led, 4'b0001);
        check("t1_err", err_cnt, 0);
        check("t1_cnt", tx_cnt, 4);

        send_line("l3");
        wait_idle();
        check("t2_led_a", led, 4'b0101);
        send_line("L3");
        wait_idle();
        check("t2_led_b", led, 4'b0001);

        send_line("L1");
        wait_idle();
        send_line("L2");
        wait_idle();
        send_line("L4");
        wait_idle();
        check("t3_led", led, 4'b1010);
        c0 = tx_cnt;
        send_line("S");
        wait_idle();
        check("t3_len", tx_cnt - c0, 3);

        e0 = err_cnt;
        send_line("L5");
        wait_idle();
        check("t4_err_a", err_cnt - e0, 1);
        send_line("ABCDEFGHIJ");
        wait_idle();
        check("t4_err_b", err_cnt - e0, 2);
        check("t4_led", led, 4'b1010);

        c0 = tx_cnt;
        send_line("L1");
        wait_tx(c0 + 1);
        send_byte("X");
        exp_drop++;
        wait_idle();
        check("t5_drop", drop_cnt, exp_drop);
        check("t5_cnt", tx_cnt - c0, 4);
        send_line("L2");
        wait_idle();
        check("t5_led", led, 4'b1001);

        c0 = tx_cnt;
        send_line("L1");
        wait_tx(c0 + 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        m_led = '0;
        @(negedge clk);
        check("t6_tx_send", tx_send, 0);
        check("t6_tx_data", tx_data, 8'h00);
        check("t6_led", led, 0);
        check("t6_cmd_err", cmd_err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        c0 = tx_cnt;
        send_line("");
        wait_idle();
        repeat (10) @(negedge clk);
        check("t6_bare_cr", tx_cnt, c0);
        send_line("L4");
        wait_idle();
        check("t6_led_b", led, 4'b1000);

        for (int it = 0; it < 40; it++) begin
            k = int'($urandom_range(0, 4));
            s = "";
            case (k)
                0: s = $sformatf("%c%c",
                       ($urandom_range(0, 1) != 0) ? "L" : "l",
                       8'h30 + 8'($urandom_range(0, 9)));
                1: s = ($urandom_range(0, 1) != 0) ? "S" : "s";
                2: begin
                    for (int j = 0; j < int'($urandom_range(1, 12)); j++)
                        s = $sformatf("%s%c", s,
                                      8'h41 + 8'($urandom_range(0, 25)));
                end
                3: s = "";
                default: s = $sformatf("L\n%c",
                             8'h31 + 8'($urandom_range(0, NL - 1)));
            endcase
            send_line(s);
            wait_idle();
            check("rnd_led", led, m_led);
        end

        check("err_total", err_cnt, exp_err);
        check("drop_total", drop_cnt, exp_drop);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
